// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for the pipelined carry-lookahead adder.
// The adder connects through the slave modport and its driver through the master modport.
interface pipelined_cla_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             gout;
  logic             pout;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero, gout, pout
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero, gout, pout
  );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit lookahead group per stage,
// group carry registered between stages, unprocessed g/p slices skewed alongside.
module pipelined_cla_adder #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipelined_cla_adder_if.slave bus
);
  localparam int NST = WIDTH / BLOCK;

  typedef struct packed {
    logic [BLOCK-1:0] s;
    logic             co;
    logic             gg;
    logic             pp;
  } grp_t;

  // Every carry is a flat sum-of-products of g/p and the group carry-in; no ripple.
  function automatic grp_t cla_group(input logic [BLOCK-1:0] g, input logic [BLOCK-1:0] p,
                                     input logic ci);
    grp_t             res;
    logic [BLOCK:0]   c;
    logic             acc;
    logic             term;
    c[0] = ci;
    for (int i = 0; i < BLOCK; i++) begin
      acc = 1'b0;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        acc = acc | term;
      end
      term = ci;
      for (int m = 0; m <= i; m++) term = term & p[m];
      c[i+1] = acc | term;
    end
    acc = 1'b0;
    for (int j = 0; j < BLOCK; j++) begin
      term = g[j];
      for (int m = j + 1; m < BLOCK; m++) term = term & p[m];
      acc = acc | term;
    end
    res.s  = p ^ c[BLOCK-1:0];
    res.co = c[BLOCK];
    res.gg = acc;
    res.pp = &p;
    return res;
  endfunction

  logic             en;
  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] g0;
  logic [WIDTH-1:0] p0;
  logic             c0;
  logic             ovf_q;
  logic             zero_q;

  // The whole pipe, output register included, advances as one when the output can move.
  assign en           = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready = en;

  assign bx = bus.sub ? ~bus.b : bus.b;
  assign g0 = bus.a & bx;
  assign p0 = bus.a ^ bx;
  assign c0 = bus.sub | bus.cin;

  for (genvar k = 0; k < NST; k++) begin : g_stg
    localparam int IW = WIDTH - k * BLOCK;
    localparam int SW = (k + 1) * BLOCK;

    logic [IW-1:0] gi;
    logic [IW-1:0] pi;
    logic          ci;
    logic          gacc_i;
    logic          pacc_i;
    logic          vi;
    grp_t          r;
    logic [SW-1:0] s_d;
    logic [SW-1:0] s_q;
    logic          c_q;
    logic          gacc_d;
    logic          gacc_q;
    logic          pacc_d;
    logic          pacc_q;
    logic          vld_q;

    // ---- stage k boundary: group k resolved from the previous stage's registers ----
    if (k == 0) begin : g_src
      assign gi     = g0;
      assign pi     = p0;
      assign ci     = c0;
      assign gacc_i = 1'b0;
      assign pacc_i = 1'b1;
      assign vi     = bus.in_valid;
      assign s_d    = r.s;
    end else begin : g_src
      assign gi     = g_stg[k-1].g_skw.gs_q;
      assign pi     = g_stg[k-1].g_skw.ps_q;
      assign ci     = g_stg[k-1].c_q;
      assign gacc_i = g_stg[k-1].gacc_q;
      assign pacc_i = g_stg[k-1].pacc_q;
      assign vi     = g_stg[k-1].vld_q;
      assign s_d    = {r.s, g_stg[k-1].s_q};
    end

    assign r      = cla_group(gi[BLOCK-1:0], pi[BLOCK-1:0], ci);
    assign gacc_d = r.gg | (r.pp & gacc_i);
    assign pacc_d = r.pp & pacc_i;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_q <= 1'b0;
      else if (en) vld_q <= vi;
    end

    if (k < NST - 1) begin : g_skw
      logic [IW-BLOCK-1:0] gs_q;
      logic [IW-BLOCK-1:0] ps_q;

      always_ff @(posedge clk) begin
        if (en) begin
          gs_q   <= gi[IW-1:BLOCK];
          ps_q   <= pi[IW-1:BLOCK];
          s_q    <= s_d;
          c_q    <= r.co;
          gacc_q <= gacc_d;
          pacc_q <= pacc_d;
        end
      end
    end else begin : g_last
      // Output register: cleared on reset, frozen while the consumer stalls.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s_q    <= '0;
          c_q    <= 1'b0;
          gacc_q <= 1'b0;
          pacc_q <= 1'b0;
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (en) begin
          s_q    <= s_d;
          c_q    <= r.co;
          gacc_q <= gacc_d;
          pacc_q <= pacc_d;
          ovf_q  <= ~pi[BLOCK-1] & (r.s[BLOCK-1] ^ gi[BLOCK-1]);
          zero_q <= ~|s_d;
        end
      end
    end
  end

  assign bus.out_valid = g_stg[NST-1].vld_q;
  assign bus.sum       = g_stg[NST-1].s_q;
  assign bus.cout      = g_stg[NST-1].c_q;
  assign bus.gout      = g_stg[NST-1].gacc_q;
  assign bus.pout      = g_stg[NST-1].pacc_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
endmodule
